bmult_pipe: RTL and testbench

Parametrised, pipelined two's-complement/unsigned W×W array multiplier with a valid/ready handshake. It generalises the one-stage Bmult6x6 in three ways: operand width is a parameter, the pipeline depth is a parameter, and a signed mode is selected per transaction. Downstream backpressure is supported. It replaces the fixed-size multipliers in the arithmetic datapath. With W=6, STAGES=1 and the handshake tied off, it reproduces Bmult6x6 cycle-for-cycle.

---
 rtl/bmult_pkg.sv | 24 ++
 rtl/bmult_stage.sv | 35 +++
 rtl/bmult_pipe.sv | 96 +++++++++
 tb/tb_bmult_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bmult_pkg.sv
// bmult_pkg: helper constants and the partial-product row function
// shared by the pipelined array multiplier and its adder stages.
package bmult_pkg;

   // Widest operand supported; rows are built at this width and trimmed
   localparam int MAX_W = 32;
   localparam int WIDE  = 2 * MAX_W;

   // One shifted partial-product row; the signed MSB row is negated
   // so that the B sign bit carries weight -2^(W-1).
   function automatic logic [WIDE-1:0] pp_row(
      input logic [WIDE-1:0] a_ext,
      input logic            b_bit,
      input int              idx,
      input logic            is_signed_msb
   );
      logic [WIDE-1:0] row;
      row = b_bit ? (a_ext << idx) : '0;
      if (is_signed_msb)
         row = ~row + WIDE'(1);
      return row;
   endfunction

endpackage

// File: rtl/bmult_stage.sv
// bmult_stage: combinational addition of R partial-product rows,
// starting at FIRST_ROW, onto an incoming 2W-bit running sum.
// Ports: sum_in/a_ext (2W), b_bits (R), is_signed -> sum_out (2W).
module bmult_stage
   import bmult_pkg::*;
#(
   parameter int W         = 6,
   parameter int R         = 1,
   parameter int FIRST_ROW = 0
) (
   input  logic [2*W-1:0] sum_in,
   input  logic [2*W-1:0] a_ext,
   input  logic [R-1:0]   b_bits,
   input  logic           is_signed,
   output logic [2*W-1:0] sum_out
);

   logic [WIDE-1:0] a_wide;
   logic [WIDE-1:0] row;
   logic [2*W-1:0]  acc;

   always_comb begin
      a_wide = '0;
      a_wide[2*W-1:0] = a_ext;
      row = '0;
      acc = sum_in;
      for (int j = 0; j < R; j++) begin
         row = pp_row(a_wide, b_bits[j], FIRST_ROW + j,
                      is_signed && (FIRST_ROW + j == W - 1));
         acc = acc + row[2*W-1:0];
      end
      sum_out = acc;
   end

endmodule

// File: rtl/bmult_pipe.sv
// bmult_pipe: pipelined W x W signed/unsigned array multiplier with a
// valid/ready handshake and a single global advance enable.
// Ports: clk, rst (sync, high); in_valid/in_ready/in_signed/A/B in;
//        out_valid/out_ready/P (2W) out.
module bmult_pipe
   import bmult_pkg::*;
#(
   parameter int W      = 6,
   parameter int STAGES = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           in_signed,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] P
);

   localparam int R  = W / STAGES;
   localparam int PW = 2 * W;

   typedef struct packed {
      logic [PW-1:0] sum;
      logic [PW-1:0] a_ext;
      logic [W-1:0]  b_rem;
      logic          sgn;
      logic          valid;
   } stage_t;

   if (W < 2 || W > MAX_W || STAGES < 1 || STAGES > W
       || (W % STAGES) != 0) begin : g_bad_param
      $error("bmult_pipe: illegal W/STAGES combination");
   end

   logic   adv;
   stage_t head;

   // The whole pipe moves as one; a stalled output freezes every stage
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv && !rst;

   always_comb begin
      head       = '0;
      head.a_ext = in_signed ? {{W{A[W-1]}}, A} : {{W{1'b0}}, A};
      head.b_rem = B;
      head.sgn   = in_signed;
      head.valid = in_valid;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stage_t        cur;
      stage_t        nxt;
      stage_t        q;
      logic [PW-1:0] sum_add;

      if (k == 0) begin : g_head
         assign cur = head;
      end else begin : g_link
         assign cur = g_stage[k-1].q;
      end

      bmult_stage #(
         .W         (W),
         .R         (R),
         .FIRST_ROW (k * R)
      ) u_stage (
         .sum_in    (cur.sum),
         .a_ext     (cur.a_ext),
         .b_bits    (cur.b_rem[R-1:0]),
         .is_signed (cur.sgn),
         .sum_out   (sum_add)
      );

      // Consumed B bits are shifted out so the next stage sees its rows at bit 0
      always_comb begin
         nxt       = cur;
         nxt.sum   = sum_add;
         nxt.b_rem = cur.b_rem >> R;
      end

      always_ff @(posedge clk) begin
         if (rst)
            q <= '0;
         else if (adv)
            q <= nxt;
      end
   end

   assign P         = g_stage[STAGES-1].q.sum;
   assign out_valid = g_stage[STAGES-1].q.valid;

endmodule

// File: tb/tb_bmult_pipe.sv
// tb_bmult_pipe: directed and random checks of bmult_pipe at W=6 with
// STAGES=1 and STAGES=3 side by side, against a queue-based product model.
module tb_bmult_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_signed;
   logic [5:0]  A;
   logic [5:0]  B;
   logic        out_ready;
   logic        in_ready1, out_valid1;
   logic [11:0] P1;
   logic        in_ready3, out_valid3;
   logic [11:0] P3;

   int total = 0;
   int bad   = 0;

   logic [11:0] q1[$];
   logic [11:0] q3[$];

   bmult_pipe #(.W(6), .STAGES(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready1),
      .in_signed (in_signed),
      .A         (A),
      .B         (B),
      .out_valid (out_valid1),
      .out_ready (out_ready),
      .P         (P1)
   );

   bmult_pipe #(.W(6), .STAGES(3)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready3),
      .in_signed (in_signed),
      .A         (A),
      .B         (B),
      .out_valid (out_valid3),
      .out_ready (out_ready),
      .P         (P3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] ref_mul(
      input logic [5:0] a,
      input logic [5:0] b,
      input logic       s
   );
      int ai;
      int bi;
      ai = s ? int'($signed(a)) : int'(a);
      bi = s ? int'($signed(b)) : int'(b);
      return 12'(ai * bi);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transfers are decided at the coming edge; inputs are stable here
   always @(negedge clk) begin
      if (rst) begin
         q1.delete();
         q3.delete();
      end else begin
         if (out_valid1 && out_ready) begin
            if (q1.size() == 0)
               chk("stale1", {20'd0, P1}, 32'hDEAD);
            else
               chk("sb1", {20'd0, P1}, {20'd0, q1.pop_front()});
         end
         if (out_valid3 && out_ready) begin
            if (q3.size() == 0)
               chk("stale3", {20'd0, P3}, 32'hDEAD);
            else
               chk("sb3", {20'd0, P3}, {20'd0, q3.pop_front()});
         end
         if (in_valid && in_ready1)
            q1.push_back(ref_mul(A, B, in_signed));
         if (in_valid && in_ready3)
            q3.push_back(ref_mul(A, B, in_signed));
      end
   end

   initial begin
      logic [5:0]  ta[5];
      logic [5:0]  tb[5];
      logic        ts[5];
      logic [11:0] tp[5];

      ta = '{6'h3F, 6'h00, 6'h20, 6'h3F, 6'h1F};
      tb = '{6'h3F, 6'h2A, 6'h20, 6'h01, 6'h3E};
      ts = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      tp = '{12'hF81, 12'h000, 12'h400, 12'hFFF, 12'hFC2};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_signed = 1'b0;
      A         = '0;
      B         = '0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst_ov1", {31'd0, out_valid1}, 0);
      chk("rst_p1",  {20'd0, P1}, 0);
      chk("rst_ir1", {31'd0, in_ready1}, 0);
      chk("rst_ov3", {31'd0, out_valid3}, 0);
      chk("rst_p3",  {20'd0, P3}, 0);
      chk("rst_ir3", {31'd0, in_ready3}, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_ir1", {31'd0, in_ready1}, 1);
      chk("post_rst_ir3", {31'd0, in_ready3}, 1);

      // Directed unsigned/signed vectors; STAGES=3 lags by two edges
      for (int i = 0; i < 5; i++) begin
         in_valid  = 1'b1;
         A         = ta[i];
         B         = tb[i];
         in_signed = ts[i];
         tick();
         chk("dir_ov1", {31'd0, out_valid1}, 1);
         chk("dir_p1", {20'd0, P1}, {20'd0, tp[i]});
         chk("dir_ov3", {31'd0, out_valid3}, (i >= 2) ? 1 : 0);
         if (i >= 2)
            chk("dir_p3", {20'd0, P3}, {20'd0, tp[i-2]});
      end
      in_valid = 1'b0;
      tick();
      chk("bubble_ov1", {31'd0, out_valid1}, 0);
      for (int i = 0; i < 4; i++) tick();
      chk("drain_ov3", {31'd0, out_valid3}, 0);

      // Back-to-back 1..4 x 5 through three stages
      for (int k = 1; k <= 8; k++) begin
         in_valid  = (k <= 4);
         in_signed = 1'b0;
         A         = 6'(k);
         B         = 6'h05;
         tick();
         chk("b2b_ov3", {31'd0, out_valid3}, (k >= 3 && k <= 6) ? 1 : 0);
         if (k >= 3 && k <= 6)
            chk("b2b_p3", {20'd0, P3}, 32'(5 * (k - 2)));
      end

      // Full pipe, output stalled for two cycles
      for (int k = 1; k <= 3; k++) begin
         in_valid = 1'b1;
         A        = 6'(k);
         tick();
      end
      A         = 6'd4;
      out_ready = 1'b0;
      #1;
      chk("stall_ir3", {31'd0, in_ready3}, 0);
      chk("stall_ir1", {31'd0, in_ready1}, 0);
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("stall_ov3", {31'd0, out_valid3}, 1);
         chk("stall_p3", {20'd0, P3}, 32'h005);
      end
      out_ready = 1'b1;
      #1;
      chk("release_ir3", {31'd0, in_ready3}, 1);
      tick();
      in_valid = 1'b0;
      for (int k = 2; k <= 4; k++) begin
         chk("release_p3", {20'd0, P3}, 32'(5 * k));
         tick();
      end
      for (int k = 0; k < 3; k++) tick();

      // Reset with two operations in flight
      in_valid = 1'b1;
      A = 6'd7;
      B = 6'd9;
      tick();
      A = 6'd2;
      B = 6'd3;
      tick();
      in_valid = 1'b0;
      rst      = 1'b1;
      tick();
      chk("mid_rst_ov3", {31'd0, out_valid3}, 0);
      chk("mid_rst_p3",  {20'd0, P3}, 0);
      chk("mid_rst_ov1", {31'd0, out_valid1}, 0);
      chk("mid_rst_p1",  {20'd0, P1}, 0);
      rst = 1'b0;
      #1;
      chk("after_rst_ir3", {31'd0, in_ready3}, 1);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("no_stale_ov3", {31'd0, out_valid3}, 0);
      end

      // Handshake tied off, then random flow control
      for (int k = 0; k < 600; k++) begin
         A         = 6'($urandom);
         B         = 6'($urandom);
         in_signed = 1'($urandom);
         if (k < 200) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
         end else begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(9) < 7);
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) tick();
      chk("empty1", q1.size(), 0);
      chk("empty3", q3.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
